// File: rtl/fpu_core.sv
// Single-cycle binary16 add/sub/mul with registered result and IEEE flags.
// Define FPU_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fpu_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] opA,
  input  logic [15:0] opB,
  input  logic [1:0]  op,
  output logic [15:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  localparam logic [15:0] QNAN = 16'h7E00;

  logic [15:0] result_d, result_q;
  logic        overflow_d, overflow_q;
  logic        underflow_d, underflow_q;
  logic        inexact_d, inexact_q;

  logic              sa, sb, ps;
  logic [4:0]        ea, eb;
  logic [9:0]        fa, fb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [10:0]       ma, mb;
  logic              swap, big_s;
  logic [4:0]        big_e, sml_e, d;
  logic [10:0]       big_m, sml_m;
  logic [13:0]       sml_x, aligned, mask, sml_al;
  logic [14:0]       sum;
  logic [3:0]        lz;
  logic [21:0]       prod;
  logic              do_round, r_sign, rnd_up;
  logic signed [7:0] r_exp, r_exp2;
  logic [13:0]       r_norm;
  logic [11:0]       rnd;

  always_comb begin
    result_d    = '0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    inexact_d   = 1'b0;
    sa     = opA[15];
    sb     = opB[15] ^ (op_e'(op) == OP_SUB);
    ps     = opA[15] ^ opB[15];
    ea     = opA[14:10];
    eb     = opB[14:10];
    fa     = opA[9:0];
    fb     = opB[9:0];
    a_nan  = (ea == 5'h1F) && (fa != '0);
    b_nan  = (eb == 5'h1F) && (fb != '0);
    a_inf  = (ea == 5'h1F) && (fa == '0);
    b_inf  = (eb == 5'h1F) && (fb == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    ma     = {1'b1, fa};
    mb     = {1'b1, fb};
    swap     = 1'b0;
    big_s    = 1'b0;
    big_e    = '0;
    sml_e    = '0;
    big_m    = '0;
    sml_m    = '0;
    d        = '0;
    sml_x    = '0;
    aligned  = '0;
    mask     = '0;
    sml_al   = '0;
    sum      = '0;
    lz       = '0;
    prod     = '0;
    do_round = 1'b0;
    r_sign   = 1'b0;
    r_exp    = '0;
    r_exp2   = '0;
    r_norm   = '0;
    rnd_up   = 1'b0;
    rnd      = '0;

    case (op_e'(op))
      OP_ADD, OP_SUB: begin
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
          result_d = QNAN;
        end else if (a_inf) begin
          result_d = {sa, 5'h1F, 10'h000};
        end else if (b_inf) begin
          result_d = {sb, 5'h1F, 10'h000};
        end else if (a_zero && b_zero) begin
          result_d = {sa & sb, 15'h0000};
        end else if (a_zero) begin
          result_d = {sb, opB[14:0]};
        end else if (b_zero) begin
          result_d = opA;
        end else begin
          swap   = opB[14:0] > opA[14:0];
          big_s  = swap ? sb : sa;
          big_e  = swap ? eb : ea;
          sml_e  = swap ? ea : eb;
          big_m  = swap ? mb : ma;
          sml_m  = swap ? ma : mb;
          d      = big_e - sml_e;
          // Three extra low bits act as guard/round/sticky; shifted-out bits fold into the LSB.
          sml_x   = {sml_m, 3'b000};
          aligned = sml_x >> d;
          mask    = (14'd1 << d) - 14'd1;
          sml_al  = {aligned[13:1], aligned[0] | (|(sml_x & mask))};
          if (sa == sb) sum = {1'b0, big_m, 3'b000} + {1'b0, sml_al};
          else          sum = {1'b0, big_m, 3'b000} - {1'b0, sml_al};
          if (sum == '0) begin
            result_d = '0;
          end else begin
            do_round = 1'b1;
            r_sign   = big_s;
            if (sum[14]) begin
              r_norm = {sum[14:2], sum[1] | sum[0]};
              r_exp  = 8'(big_e) + 8'sd1;
            end else begin
              for (int unsigned i = 0; i < 14; i++)
                if (sum[i]) lz = 4'(13 - i);
              r_norm = sum[13:0] << lz;
              r_exp  = 8'(big_e) - 8'(lz);
            end
          end
        end
      end
      OP_MUL: begin
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
          result_d = QNAN;
        end else if (a_inf || b_inf) begin
          result_d = {ps, 5'h1F, 10'h000};
        end else if (a_zero || b_zero) begin
          result_d = {ps, 15'h0000};
        end else begin
          do_round = 1'b1;
          r_sign   = ps;
          prod     = ma * mb;
          if (prod[21]) begin
            r_norm = {prod[21:9], |prod[8:0]};
            r_exp  = 8'(ea) + 8'(eb) - 8'sd14;
          end else begin
            r_norm = {prod[20:8], |prod[7:0]};
            r_exp  = 8'(ea) + 8'(eb) - 8'sd15;
          end
        end
      end
      default: ;
    endcase

    if (do_round) begin
      inexact_d = |r_norm[2:0];
`ifdef FPU_RNE_EN
      rnd_up = r_norm[2] & ((|r_norm[1:0]) | r_norm[3]);
`else
      rnd_up = 1'b0;
`endif
      rnd    = {1'b0, r_norm[13:3]} + 12'(rnd_up);
      r_exp2 = rnd[11] ? r_exp + 8'sd1 : r_exp;
      // Underflow judges the exact (pre-rounding) exponent.
      if (r_exp < 8'sd1) begin
        result_d    = {r_sign, 15'h0000};
        underflow_d = 1'b1;
        inexact_d   = 1'b1;
      end else if (r_exp2 > 8'sd30) begin
`ifdef FPU_RNE_EN
        result_d = {r_sign, 5'h1F, 10'h000};
`else
        result_d = {r_sign, 15'h7BFF};
`endif
        overflow_d = 1'b1;
        inexact_d  = 1'b1;
      end else begin
        result_d = {r_sign, r_exp2[4:0], rnd[11] ? rnd[10:1] : rnd[9:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      inexact_q   <= inexact_d;
    end
  end

  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_fpu_core.sv
// Directed bench for fpu_core: hand-computed binary16 vectors checked one cycle after sampling.
module tb_fpu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] opA = '0;
  logic [15:0] opB = '0;
  logic [1:0]  op = '0;
  logic [15:0] result;
  logic        overflow, underflow, inexact;

  int n_checks = 0;
  int n_fail = 0;

  fpu_core dut (
    .clk       (clk),
    .reset     (reset),
    .opA       (opA),
    .opB       (opB),
    .op        (op),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] er,
                       input logic eo, input logic eu, input logic ei);
    n_checks++;
    assert ({result, overflow, underflow, inexact} === {er, eo, eu, ei})
    else begin
      n_fail++;
      $error("FAIL %s: observed result=%h o/u/i=%b%b%b expected result=%h o/u/i=%b%b%b",
             tag, result, overflow, underflow, inexact, er, eo, eu, ei);
    end
  endtask

  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] o, input logic [15:0] er,
                      input logic eo, input logic eu, input logic ei);
    opA = a;
    opB = b;
    op  = o;
    @(posedge clk);
    #1;
    check(tag, er, eo, eu, ei);
  endtask

  initial begin
    #2;
    check("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);
    #10;
    reset = 1'b1;

    step("add_1p1",      16'h3C00, 16'h3C00, 2'b00, 16'h4000, 1'b0, 1'b0, 1'b0);
    step("add_tie_even", 16'h3C00, 16'h1000, 2'b00, 16'h3C00, 1'b0, 1'b0, 1'b1);
`ifdef FPU_RNE_EN
    step("mul_ovf",      16'h7BFF, 16'h4000, 2'b10, 16'h7C00, 1'b1, 1'b0, 1'b1);
    step("add_tie_odd",  16'h3C01, 16'h1000, 2'b00, 16'h3C02, 1'b0, 1'b0, 1'b1);
    step("add_ovf",      16'h7BFF, 16'h7BFF, 2'b00, 16'h7C00, 1'b1, 1'b0, 1'b1);
`else
    step("mul_ovf",      16'h7BFF, 16'h4000, 2'b10, 16'h7BFF, 1'b1, 1'b0, 1'b1);
    step("add_tie_odd",  16'h3C01, 16'h1000, 2'b00, 16'h3C01, 1'b0, 1'b0, 1'b1);
    step("add_ovf",      16'h7BFF, 16'h7BFF, 2'b00, 16'h7BFF, 1'b1, 1'b0, 1'b1);
`endif
    step("flags_clear",  16'h3C00, 16'h3C00, 2'b00, 16'h4000, 1'b0, 1'b0, 1'b0);
    step("mul_unf",      16'h0400, 16'h3800, 2'b10, 16'h0000, 1'b0, 1'b1, 1'b1);
    step("sub_zero",     16'h3C00, 16'h3C00, 2'b01, 16'h0000, 1'b0, 1'b0, 1'b0);
    step("inf_m_inf",    16'h7C00, 16'hFC00, 2'b00, 16'h7E00, 1'b0, 1'b0, 1'b0);
    step("op_reserved",  16'h3C00, 16'h3C00, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b0);
    step("negz_negz",    16'h8000, 16'h8000, 2'b00, 16'h8000, 1'b0, 1'b0, 1'b0);
    step("mul_2xm3",     16'h4000, 16'hC200, 2'b10, 16'hC600, 1'b0, 1'b0, 1'b0);
    step("mul_0xinf",    16'h0000, 16'h7C00, 2'b10, 16'h7E00, 1'b0, 1'b0, 1'b0);
    step("mul_infxm2",   16'h7C00, 16'hC000, 2'b10, 16'hFC00, 1'b0, 1'b0, 1'b0);
    step("subnorm_in",   16'h0001, 16'h3C00, 2'b00, 16'h3C00, 1'b0, 1'b0, 1'b0);
    step("nan_in",       16'h7C01, 16'h3C00, 2'b00, 16'h7E00, 1'b0, 1'b0, 1'b0);
    step("sub_3m1",      16'h4200, 16'h3C00, 2'b01, 16'h4000, 1'b0, 1'b0, 1'b0);
    step("mul_negzero",  16'h8000, 16'h3C00, 2'b10, 16'h8000, 1'b0, 1'b0, 1'b0);
    step("sub_unf",      16'h0401, 16'h0400, 2'b01, 16'h0000, 1'b0, 1'b1, 1'b1);
    step("sub_neg",      16'h3C00, 16'h4000, 2'b01, 16'hBC00, 1'b0, 1'b0, 1'b0);

    // Mid-stream reset: outputs clear without a clock edge, next edge after release is valid.
    step("pre_reset",    16'h7BFF, 16'h7BFF, 2'b00,
`ifdef FPU_RNE_EN
         16'h7C00,
`else
         16'h7BFF,
`endif
         1'b1, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    opA = 16'h4000;
    opB = 16'hC200;
    op  = 2'b10;
    #2;
    reset = 1'b1;
    #1;
    check("held_after_release", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("first_after_reset", 16'hC600, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
